// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of the 32-bit ALU: decodes opcode/funct into an ALU op,
// selects/extends operand B and holds up to two decoded entries in a skid buffer.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic [4:0]        in_rt_addr,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_operation,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [4:0]        out_dest,
  output logic              out_illegal
);

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        dest;
    logic              ill;
  } entry_t;

  entry_t      dec;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [DATA_W-1:0] sext, zext;
  logic        push, pop;

  assign sext = {{(DATA_W-16){in_imm[15]}}, in_imm};
  assign zext = {{(DATA_W-16){1'b0}}, in_imm};

  always_comb begin
    dec.op   = 4'b0000;
    dec.a    = in_rs_data;
    dec.b    = in_rt_data;
    dec.dest = 5'd0;
    dec.ill  = 1'b0;
    if (in_opcode == 6'h00) begin
      dec.dest = in_rd_addr;
      case (in_funct)
        6'h20:   dec.op = 4'b0001;
        6'h22:   dec.op = 4'b0010;
        6'h24:   dec.op = 4'b0011;
        6'h25:   dec.op = 4'b0100;
        6'h2A:   dec.op = 4'b0111;
        default: dec.ill = 1'b1;
      endcase
    end else begin
      case (in_opcode)
        6'h08, 6'h23, 6'h2B: begin dec.op = 4'b0001; dec.b = sext; dec.dest = in_rt_addr; end
        6'h0A: begin dec.op = 4'b0111; dec.b = sext; dec.dest = in_rt_addr; end
        6'h0C: begin dec.op = 4'b0011; dec.b = zext; dec.dest = in_rt_addr; end
        6'h0D: begin dec.op = 4'b0100; dec.b = zext; dec.dest = in_rt_addr; end
        // lui only passes the raw immediate; the ALU applies the shift
        6'h0F: begin dec.op = 4'b1000; dec.b = zext; dec.dest = in_rt_addr; end
        6'h04: dec.op = 4'b0010;
        default: dec.ill = 1'b1;
      endcase
    end
  end

  assign in_ready  = rst_n & (count_q < 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head slot is always the visible entry; tail only fills while the head is held
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (in_flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = dec;
          else                 tail_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: head_d = dec;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_operation = head_q.op;
  assign out_A         = head_q.a;
  assign out_B         = head_q.b;
  assign out_dest      = head_q.dest;
  assign out_illegal   = head_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode/extension, back-pressure, streaming,
// flush and reset behaviour, with hand-computed expected values.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_flush, out_valid, out_ready, out_illegal;
  logic [5:0]  in_opcode, in_funct;
  logic [31:0] in_rs_data, in_rt_data, out_A, out_B;
  logic [15:0] in_imm;
  logic [4:0]  in_rt_addr, in_rd_addr, out_dest;
  logic [3:0]  out_operation;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_flush(in_flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_operation(out_operation), .out_A(out_A),
    .out_B(out_B), .out_dest(out_dest), .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [15:0] imm,
                               input logic [4:0] rta, input logic [4:0] rda);
    in_opcode  = op;
    in_funct   = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm     = imm;
    in_rt_addr = rta;
    in_rd_addr = rda;
    in_valid   = 1'b1;
  endtask

  // One instruction through an empty stage with out_ready = 1
  task automatic checkDecode(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                             input logic [4:0] rta, input logic [4:0] rda, input logic [3:0] expOp,
                             input logic [31:0] expB, input logic [4:0] expDest, input logic expIll);
    applyStimulus(op, fn, rs, rt, imm, rta, rda);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_op"}, 32'(out_operation), 32'(expOp));
    checkOutput({tag, "_A"}, out_A, rs);
    checkOutput({tag, "_B"}, out_B, expB);
    checkOutput({tag, "_dest"}, 32'(out_dest), 32'(expDest));
    checkOutput({tag, "_ill"}, 32'(out_illegal), 32'(expIll));
    tick();
    checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
    applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0);
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_op", 32'(out_operation), 32'd0);
    checkOutput("rst_A", out_A, 32'd0);
    checkOutput("rst_B", out_B, 32'd0);
    checkOutput("rst_dest", 32'(out_dest), 32'd0);
    checkOutput("rst_ill", 32'(out_illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    checkDecode("add",   6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 5'd9, 5'd3, 4'b0001, 32'd7, 5'd3, 1'b0);
    checkDecode("addi",  6'h08, 6'h00, 32'd1, 32'd2, 16'hFFFF, 5'd4, 5'd11, 4'b0001, 32'hFFFF_FFFF, 5'd4, 1'b0);
    checkDecode("ori",   6'h0D, 6'h00, 32'd9, 32'd2, 16'hFFFF, 5'd6, 5'd11, 4'b0100, 32'h0000_FFFF, 5'd6, 1'b0);
    checkDecode("lui",   6'h0F, 6'h00, 32'd0, 32'd2, 16'h1234, 5'd8, 5'd11, 4'b1000, 32'h0000_1234, 5'd8, 1'b0);
    checkDecode("slti",  6'h0A, 6'h00, 32'd3, 32'd2, 16'h8000, 5'd7, 5'd11, 4'b0111, 32'hFFFF_8000, 5'd7, 1'b0);
    checkDecode("andi",  6'h0C, 6'h00, 32'd3, 32'd2, 16'h8000, 5'd7, 5'd11, 4'b0011, 32'h0000_8000, 5'd7, 1'b0);
    checkDecode("sw",    6'h2B, 6'h00, 32'd3, 32'd2, 16'hFFFC, 5'd12, 5'd11, 4'b0001, 32'hFFFF_FFFC, 5'd12, 1'b0);
    checkDecode("beq",   6'h04, 6'h00, 32'd3, 32'h77, 16'h0010, 5'd5, 5'd11, 4'b0010, 32'h77, 5'd0, 1'b0);
    checkDecode("slt",   6'h00, 6'h2A, 32'd3, 32'h44, 16'h0000, 5'd5, 5'd13, 4'b0111, 32'h44, 5'd13, 1'b0);
    checkDecode("badfn", 6'h00, 6'h3F, 32'd3, 32'h44, 16'h0000, 5'd5, 5'd13, 4'b0000, 32'h44, 5'd13, 1'b1);
    checkDecode("badop", 6'h3F, 6'h00, 32'd3, 32'h55, 16'h1111, 5'd5, 5'd13, 4'b0000, 32'h55, 5'd0, 1'b1);

    // Back-pressure: three offers while stalled, then drain in order
    out_ready = 1'b0;
    applyStimulus(6'h00, 6'h20, 32'h10, 32'h11, 16'h0, 5'd0, 5'd1);
    tick();
    checkOutput("bp1_valid", 32'(out_valid), 32'd1);
    checkOutput("bp1_ready", 32'(in_ready), 32'd1);
    checkOutput("bp1_A", out_A, 32'h10);
    applyStimulus(6'h00, 6'h22, 32'h20, 32'h21, 16'h0, 5'd0, 5'd2);
    tick();
    checkOutput("bp2_ready", 32'(in_ready), 32'd0);
    checkOutput("bp2_A", out_A, 32'h10);
    checkOutput("bp2_op", 32'(out_operation), 32'd1);
    applyStimulus(6'h00, 6'h24, 32'h30, 32'h31, 16'h0, 5'd0, 5'd3);
    tick();
    checkOutput("bp3_ready", 32'(in_ready), 32'd0);
    checkOutput("bp3_A", out_A, 32'h10);
    checkOutput("bp3_B", out_B, 32'h11);
    checkOutput("bp3_dest", 32'(out_dest), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("drB_A", out_A, 32'h20);
    checkOutput("drB_op", 32'(out_operation), 32'd2);
    checkOutput("drB_dest", 32'(out_dest), 32'd2);
    checkOutput("drB_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("drC_valid", 32'(out_valid), 32'd1);
    checkOutput("drC_A", out_A, 32'h30);
    checkOutput("drC_op", 32'(out_operation), 32'd3);
    tick();
    checkOutput("dr_empty", 32'(out_valid), 32'd0);

    // Push and pop together at count 1 replaces the head
    applyStimulus(6'h00, 6'h25, 32'h40, 32'h41, 16'h0, 5'd0, 5'd4);
    tick();
    checkOutput("pp_first_A", out_A, 32'h40);
    applyStimulus(6'h00, 6'h2A, 32'h50, 32'h51, 16'h0, 5'd0, 5'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("pp_valid", 32'(out_valid), 32'd1);
    checkOutput("pp_A", out_A, 32'h50);
    checkOutput("pp_op", 32'(out_operation), 32'd7);
    tick();
    checkOutput("pp_empty", 32'(out_valid), 32'd0);

    // Streaming ten back-to-back instructions
    for (int i = 0; i < 10; i++) begin
      applyStimulus(6'h00, 6'h20, 32'(100 + i), 32'd1, 16'h0, 5'd0, 5'd6);
      tick();
      checkOutput($sformatf("str%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("str%0d_A", i), out_A, 32'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    checkOutput("str_empty", 32'(out_valid), 32'd0);

    // Flush at count 2 with a valid input on the flush cycle
    out_ready = 1'b0;
    applyStimulus(6'h00, 6'h20, 32'hA1, 32'd0, 16'h0, 5'd0, 5'd7);
    tick();
    applyStimulus(6'h00, 6'h20, 32'hA2, 32'd0, 16'h0, 5'd0, 5'd7);
    tick();
    checkOutput("fl_full", 32'(in_ready), 32'd0);
    applyStimulus(6'h00, 6'h20, 32'hA3, 32'd0, 16'h0, 5'd0, 5'd7);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("fl_gone1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("fl_gone2", 32'(out_valid), 32'd0);

    // Reset with two buffered entries
    out_ready = 1'b0;
    applyStimulus(6'h00, 6'h20, 32'hB1, 32'd0, 16'h0, 5'd0, 5'd8);
    tick();
    applyStimulus(6'h00, 6'h20, 32'hB2, 32'd0, 16'h0, 5'd0, 5'd8);
    tick();
    in_valid = 1'b0;
    checkOutput("rs_full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("rs_valid", 32'(out_valid), 32'd0);
    checkOutput("rs_ready", 32'(in_ready), 32'd0);
    checkOutput("rs_A", out_A, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rs_rel_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("rs_rel_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
